// File: rtl/calc_pkg.sv
// Shared types and widths for the calculator command driver.
package calc_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/calc_timeout_ctr.sv
// RUN-cycle watchdog: cleared on RUN entry, counts while enabled,
// flags the cycle whose increment reaches TIMEOUT_CYCLES.
module calc_timeout_ctr
    import calc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_inc;

    always_comb begin
        cnt_inc = cnt_q + W'(1);
        cnt_d   = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_inc;
        end
    end

    // Expiry is judged on the value this edge would store.
    assign expired = enable && (cnt_inc == W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/calc_driver.sv
// Command/result handshake driver for a level-started calculator.
// Optional RUN watchdog enabled by defining CALC_TIMEOUT_EN.
module calc_driver
    import calc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [DATA_W-1:0] cmd_x,
    input  logic [DATA_W-1:0] cmd_y,
    output logic              go_calc,
    output logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] x,
    output logic [DATA_W-1:0] y,
    input  logic              done,
    input  logic [DATA_W-1:0] calc_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_err,
    output logic [CNT_W-1:0]  op_count,
    output logic              busy
);

    state_t              state_q, state_d;
    logic                go_calc_q, go_calc_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [DATA_W-1:0]   x_q, x_d;
    logic [DATA_W-1:0]   y_q, y_d;
    logic                res_valid_q, res_valid_d;
    logic [DATA_W-1:0]   res_data_q, res_data_d;
    logic [CNT_W-1:0]    op_count_q, op_count_d;

`ifdef CALC_TIMEOUT_EN
    logic res_err_q, res_err_d;
    logic tmo_expired;

    calc_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q == IDLE),
        .enable  (state_q == RUN),
        .expired (tmo_expired)
    );

    assign res_err = res_err_q;
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = |TIMEOUT_CYCLES;
    assign res_err = 1'b0;
`endif

    assign cmd_ready = (state_q == IDLE) && !done;
    assign busy      = (state_q != IDLE);
    assign go_calc   = go_calc_q;
    assign op        = op_q;
    assign x         = x_q;
    assign y         = y_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign op_count  = op_count_q;

    always_comb begin
        state_d     = state_q;
        go_calc_d   = go_calc_q;
        op_d        = op_q;
        x_d         = x_q;
        y_d         = y_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        op_count_d  = op_count_q;
`ifdef CALC_TIMEOUT_EN
        res_err_d   = res_err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_d      = cmd_op;
                    x_d       = cmd_x;
                    y_d       = cmd_y;
                    go_calc_d = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                // A done coinciding with expiry takes priority as a normal result.
                if (done) begin
                    res_data_d  = calc_out;
                    res_valid_d = 1'b1;
                    go_calc_d   = 1'b0;
                    state_d     = DRAIN;
`ifdef CALC_TIMEOUT_EN
                    res_err_d   = 1'b0;
                end else if (tmo_expired) begin
                    res_data_d  = '0;
                    res_err_d   = 1'b1;
                    res_valid_d = 1'b1;
                    go_calc_d   = 1'b0;
                    state_d     = DRAIN;
`endif
                end
            end
            DRAIN: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                    if (!res_err) begin
                        op_count_d = op_count_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            go_calc_q   <= 1'b0;
            op_q        <= '0;
            x_q         <= '0;
            y_q         <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            op_count_q  <= '0;
`ifdef CALC_TIMEOUT_EN
            res_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            go_calc_q   <= go_calc_d;
            op_q        <= op_d;
            x_q         <= x_d;
            y_q         <= y_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            op_count_q  <= op_count_d;
`ifdef CALC_TIMEOUT_EN
            res_err_q   <= res_err_d;
`endif
        end
    end

endmodule
